// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_stopwatch : 6-digit BCD MM:SS.cc stopwatch, debounced SS/LAP/CLR buttons
// Revision      : 1.0
// ----------------------------------------------------------------------------
module bcd_stopwatch #(
  parameter int CLK_DIV_CS = 100000,
  parameter int SCAN_DIV   = 2500,
  parameter int DB_CYCLES  = 200000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_SS,
  input  logic       BTN_LAP,
  input  logic       BTN_CLR,
  output logic       ENABLE,
  output logic [3:0] L1,
  output logic [3:0] L2,
  output logic [3:0] L3,
  output logic [3:0] L4,
  output logic [3:0] L5,
  output logic [3:0] L6,
  output logic       RUNNING,
  output logic       OVF
);

  localparam int CS_W = (CLK_DIV_CS > 1) ? $clog2(CLK_DIV_CS) : 1;
  localparam int SC_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int DB_W = (DB_CYCLES  > 1) ? $clog2(DB_CYCLES)  : 1;
  // Per-digit terminal values, packed like the count: {m10,m1,s10,s1,c10,c1}
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      btn_raw;
  logic [2:0]      rise;
  logic            ev_ss;
  logic            ev_lap;
  logic            ev_clr;
  logic            clear;
  logic            running;
  logic            tick;
  logic            carry;
  logic            wrap;
  logic [CS_W-1:0] cs_cnt;
  logic [SC_W-1:0] scan_cnt;
  logic [23:0]     cnt;
  logic [23:0]     cnt_nxt;
  logic [23:0]     shown;

  assign btn_raw = {BTN_CLR, BTN_LAP, BTN_SS};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic            s1;
    logic            s2;
    logic            lvl;
    logic [DB_W-1:0] db_cnt;
    logic            accept;

    // db_cnt counts consecutive samples that disagree with the accepted level
    assign accept  = (s2 != lvl) && (db_cnt == DB_W'(DB_CYCLES - 1));
    assign rise[i] = accept & s2;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        lvl    <= 1'b0;
        db_cnt <= '0;
      end else begin
        s1 <= btn_raw[i];
        s2 <= s1;
        if (s2 == lvl) begin
          db_cnt <= '0;
        end else if (accept) begin
          lvl    <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

  assign ev_clr = rise[2];
  assign ev_ss  = rise[0] & ~rise[2];
  assign ev_lap = rise[1] & ~rise[0] & ~rise[2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      S_IDLE: if (ev_ss) state_nxt = S_RUN;
      S_RUN: begin
        if (ev_ss)       state_nxt = S_STOP;
        else if (ev_lap) state_nxt = S_LAP;
      end
      S_LAP: begin
        if (ev_ss)       state_nxt = S_STOP;
        else if (ev_lap) state_nxt = S_RUN;
      end
      S_STOP: begin
        if (ev_clr) begin
          state_nxt = S_IDLE;
          clear     = 1'b1;
        end else if (ev_ss) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign running = (state == S_RUN) || (state == S_LAP);
  assign tick    = running && (cs_cnt == CS_W'(CLK_DIV_CS - 1));
  assign RUNNING = running;

  // Prescaler holds its partial period while stopped
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     cs_cnt <= '0;
    else if (clear)   cs_cnt <= '0;
    else if (tick)    cs_cnt <= '0;
    else if (running) cs_cnt <= cs_cnt + 1'b1;
  end

  always_comb begin
    cnt_nxt = cnt;
    carry   = tick;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
          cnt_nxt[4*i +: 4] = 4'd0;
        end else begin
          cnt_nxt[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      OVF <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      OVF <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) OVF <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)            shown <= '0;
    else if (state != S_LAP) shown <= cnt;
  end

  assign L1 = shown[3:0];
  assign L2 = shown[7:4];
  assign L3 = shown[11:8];
  assign L4 = shown[15:12];
  assign L5 = shown[19:16];
  assign L6 = shown[23:20];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_cnt <= '0;
      ENABLE   <= 1'b0;
    end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      ENABLE   <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      ENABLE   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bcd_stopwatch : directed scoreboard bench for bcd_stopwatch (small dividers)
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_bcd_stopwatch;

  localparam int CLK_DIV_CS = 4;
  localparam int SCAN_DIV   = 3;
  localparam int DB_CYCLES  = 2;

  logic       CLK     = 1'b0;
  logic       RESET_N = 1'b1;
  logic       BTN_SS  = 1'b0;
  logic       BTN_LAP = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic       ENABLE;
  logic       RUNNING;
  logic       OVF;
  logic [3:0] L1, L2, L3, L4, L5, L6;

  bcd_stopwatch #(
    .CLK_DIV_CS(CLK_DIV_CS),
    .SCAN_DIV  (SCAN_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .BTN_SS (BTN_SS),
    .BTN_LAP(BTN_LAP),
    .BTN_CLR(BTN_CLR),
    .ENABLE (ENABLE),
    .L1     (L1),
    .L2     (L2),
    .L3     (L3),
    .L4     (L4),
    .L5     (L5),
    .L6     (L6),
    .RUNNING(RUNNING),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  function automatic logic [23:0] disp();
    return {L6, L5, L4, L3, L2, L1};
  endfunction

  task automatic compare(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic [23:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic chk(input logic [23:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow: observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      compare(e.tag, obs, e.val);
    end
  endtask

  // One clock; ENABLE must pulse on every SCAN_DIV-th edge after reset release
  task automatic step();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    compare("enable", {23'd0, ENABLE}, ((cyc % SCAN_DIV) == 0) ? 24'd1 : 24'd0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    push_exp("rst_disp", 24'h0);    chk(disp());
    push_exp("rst_running", 24'h0); chk({23'd0, RUNNING});
    push_exp("rst_ovf", 24'h0);     chk({23'd0, OVF});
    push_exp("rst_enable", 24'h0);  chk({23'd0, ENABLE});
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    cyc     = 0;
  endtask

  // Event lands on the 4th edge (2 sync + 2 debounce samples); returns just after it
  task automatic press(input int which);
    case (which)
      0:       BTN_SS  = 1'b1;
      1:       BTN_LAP = 1'b1;
      default: BTN_CLR = 1'b1;
    endcase
    repeat (4) step();
    BTN_SS  = 1'b0;
    BTN_LAP = 1'b0;
    BTN_CLR = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    repeat (4) step();

    // Start and run 10 ticks, then asynchronous reset mid-run
    press(0);
    push_exp("run_after_ss", 24'h1); chk({23'd0, RUNNING});
    push_exp("disp_10_ticks", 24'h000010);
    repeat (41) step();
    chk(disp());
    push_exp("running_40", 24'h1); chk({23'd0, RUNNING});
    do_reset();
    repeat (2) step();

    // Wrap 59:59.99 -> 00:00.00
    press(0);
    force dut.cnt = 24'h595999;
    step();
    release dut.cnt;
    push_exp("wrap_pre_disp", 24'h595999); chk(disp());
    push_exp("wrap_pre_ovf", 24'h0);       chk({23'd0, OVF});
    repeat (3) step();
    push_exp("wrap_ovf", 24'h1);           chk({23'd0, OVF});
    step();
    push_exp("wrap_disp", 24'h000000);     chk(disp());
    repeat (4) step();
    push_exp("count_after_wrap", 24'h000001); chk(disp());

    // CLR ignored in RUN; SS then CLR clears
    press(2);
    push_exp("clr_in_run_running", 24'h1); chk({23'd0, RUNNING});
    push_exp("clr_in_run_ovf", 24'h1);     chk({23'd0, OVF});
    press(0);
    push_exp("ss_stop", 24'h0);            chk({23'd0, RUNNING});
    press(2);
    push_exp("clr_ovf", 24'h0);            chk({23'd0, OVF});
    push_exp("clr_running", 24'h0);        chk({23'd0, RUNNING});
    step();
    push_exp("clr_disp", 24'h000000);      chk(disp());

    // Lap freeze at 05, release when internal count is 10
    press(0);
    repeat (17) step();
    press(1);
    push_exp("lap_entry_disp", 24'h000005); chk(disp());
    push_exp("lap_running", 24'h1);         chk({23'd0, RUNNING});
    repeat (15) step();
    push_exp("lap_hold", 24'h000005);       chk(disp());
    step();
    press(1);
    push_exp("lap_exit_edge", 24'h000005);  chk(disp());
    step();
    push_exp("lap_live", 24'h000010);       chk(disp());

    // Stop two cycles into a period, resume continues the partial period
    repeat (4) step();
    press(0);
    push_exp("stop_running", 24'h0);        chk({23'd0, RUNNING});
    repeat (6) step();
    push_exp("stop_hold", 24'h000012);      chk(disp());
    press(0);
    push_exp("resume_running", 24'h1);      chk({23'd0, RUNNING});
    repeat (2) step();
    push_exp("resume_pre_tick", 24'h000012); chk(disp());
    step();
    push_exp("resume_tick", 24'h000013);    chk(disp());

    // Glitch rejection and same-cycle SS+LAP priority
    repeat (4) step();
    BTN_SS = 1'b1;
    step();
    BTN_SS = 1'b0;
    repeat (6) step();
    push_exp("glitch_ignored", 24'h1);      chk({23'd0, RUNNING});
    BTN_SS  = 1'b1;
    BTN_LAP = 1'b1;
    repeat (4) step();
    BTN_SS  = 1'b0;
    BTN_LAP = 1'b0;
    push_exp("ss_lap_stop", 24'h0);         chk({23'd0, RUNNING});
    repeat (4) step();
    press(1);
    push_exp("lap_in_stop_ignored", 24'h0); chk({23'd0, RUNNING});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
